// File: rtl/chan_arb_pkg.sv
// Shared types and helpers for the multi-channel arbitrated ingress block.
// Optional statistics are enabled with the CHAN_STATS_EN macro.
package chan_arb_pkg;

  typedef enum int {
    ARB_RR    = 0,
    ARB_FIXED = 1
  } arb_mode_e;

  localparam int STALL_W = 16;
  localparam int MAX_CH  = 16;

  // Round-robin search starting just after ptr, wrapping modulo num_ch.
  // Returns ptr when nothing is requested; callers qualify with |req.
  function automatic logic [3:0] next_rr_grant(
    input logic [MAX_CH-1:0] req,
    input logic [3:0]        ptr,
    input int                num_ch
  );
    logic [3:0] grant;
    logic       found;
    int         idx;
    grant = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_ch) idx = idx - num_ch;
      if (!found && (i <= num_ch) && req[idx[3:0]]) begin
        grant = idx[3:0];
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/chan_arb_array_if.sv
// Ingress/egress bundle of chan_arb_array; stall_cnt exists only with CHAN_STATS_EN.
interface chan_arb_array_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_ready;
  logic [NUM_CH-1:0]    ch_empty;
`ifdef CHAN_STATS_EN
  logic [NUM_CH*chan_arb_pkg::STALL_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, ch_empty, stall_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, ch_empty, stall_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, ch_empty
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, ch_empty
  );
`endif

endinterface

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO with a combinational head read so a pop
// and the output-register load happen on the same edge.
module chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses writes even while it is being drained.
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/chan_arb_array.sv
// NUM_CH buffered ingress channels merged into one registered output stream.
// Define CHAN_STATS_EN to add per-channel saturating stall counters.
module chan_arb_array
  import chan_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input logic             clk,
  input logic             rst,
  chan_arb_array_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] req;
  logic [DW-1:0]     rdata [NUM_CH];
  logic [CW-1:0]     grant_idx;
  logic              load_en;
  logic              grant_vld;
  logic              out_valid_reg;
  logic [DW-1:0]     out_data_reg;
  logic [CW-1:0]     out_ch_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_fifo
      chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid[gi]),
        .wdata (bus.in_data[gi*DW +: DW]),
        .pop   (pop[gi]),
        .full  (full[gi]),
        .empty (empty[gi]),
        .rdata (rdata[gi])
      );
    end
  endgenerate

  assign bus.in_ready = ~full;
  assign bus.ch_empty = empty;
  assign req          = ~empty;
  assign load_en      = ~out_valid_reg | bus.out_ready;
  assign grant_vld    = load_en & (|req);
  assign pop          = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

  generate
    case (ARB_MODE)
      int'(ARB_RR): begin : g_rr
        logic [CW-1:0] ptr_reg;
        assign grant_idx = CW'(next_rr_grant(MAX_CH'(req), 4'(ptr_reg), NUM_CH));
        // Pointer starts at the last channel so channel 0 wins first.
        always_ff @(posedge clk) begin
          if (rst)            ptr_reg <= CW'(NUM_CH - 1);
          else if (grant_vld) ptr_reg <= grant_idx;
        end
      end
      int'(ARB_FIXED): begin : g_fixed
        always_comb begin
          grant_idx = '0;
          for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = CW'(i);
          end
        end
      end
      default: begin : g_bad_mode
        $error("chan_arb_array: unsupported ARB_MODE %0d", ARB_MODE);
      end
    endcase
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (load_en) begin
      out_valid_reg <= |req;
      if (|req) begin
        out_data_reg <= rdata[grant_idx];
        out_ch_reg   <= grant_idx;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;

`ifdef CHAN_STATS_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
      logic [STALL_W-1:0] stall_cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          stall_cnt_reg <= '0;
        end else if (bus.in_valid[gi] && full[gi] && (stall_cnt_reg != '1)) begin
          stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
        end
      end
      assign bus.stall_cnt[gi*STALL_W +: STALL_W] = stall_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_chan_arb_array.sv
// Directed bench: round-robin and fixed-priority instances driven with identical stimulus.
module tb_chan_arb_array;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_arb_array_if #(.NUM_CH(NUM_CH), .DW(DW)) if_rr ();
  chan_arb_array_if #(.NUM_CH(NUM_CH), .DW(DW)) if_fx ();

  assign if_rr.in_valid  = in_valid;
  assign if_rr.in_data   = in_data;
  assign if_rr.out_ready = out_ready;
  assign if_fx.in_valid  = in_valid;
  assign if_fx.in_data   = in_data;
  assign if_fx.out_ready = out_ready;

  chan_arb_array #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr.slave)
  );

  chan_arb_array #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(1)) u_fx (
    .clk (clk),
    .rst (rst),
    .bus (if_fx.slave)
  );

  typedef struct {
    logic [1:0] rr_ch;
    logic [7:0] rr_data;
    logic [1:0] fx_ch;
    logic [7:0] fx_data;
  } seq_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  seq_vec_t seq_tab [8];
  logic [7:0] drain_exp [5];

  initial begin
    // RR emits channel order 0..3 twice; fixed priority drains each channel fully.
    seq_tab[0] = '{2'd0, 8'h00, 2'd0, 8'h00};
    seq_tab[1] = '{2'd1, 8'h10, 2'd0, 8'h01};
    seq_tab[2] = '{2'd2, 8'h20, 2'd1, 8'h10};
    seq_tab[3] = '{2'd3, 8'h30, 2'd1, 8'h11};
    seq_tab[4] = '{2'd0, 8'h01, 2'd2, 8'h20};
    seq_tab[5] = '{2'd1, 8'h11, 2'd2, 8'h21};
    seq_tab[6] = '{2'd2, 8'h21, 2'd3, 8'h30};
    seq_tab[7] = '{2'd3, 8'h31, 2'd3, 8'h31};
    drain_exp  = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};

    // Reset state
    do_reset();
    chk("reset in_ready",  32'(if_rr.in_ready),  32'hF);
    chk("reset ch_empty",  32'(if_rr.ch_empty),  32'hF);
    chk("reset out_valid", 32'(if_rr.out_valid), 32'h0);
    chk("reset out_data",  32'(if_rr.out_data),  32'h0);
    chk("reset out_ch",    32'(if_rr.out_ch),    32'h0);

    // Single word, minimum latency
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_data[2*DW +: DW] = 8'hA5;
    tick();
    in_valid = '0;
    chk("single ch_empty",  32'(if_rr.ch_empty),  32'hB);
    chk("single out_valid0", 32'(if_rr.out_valid), 32'h0);
    tick();
    chk("single out_valid", 32'(if_rr.out_valid), 32'h1);
    chk("single out_data",  32'(if_rr.out_data),  32'hA5);
    chk("single out_ch",    32'(if_rr.out_ch),    32'h2);
    tick();
    chk("single idle after", 32'(if_rr.out_valid), 32'h0);

    // Two words per channel, then full-rate drain
    do_reset();
    for (int w = 0; w < 2; w++) begin
      in_valid = 4'hF;
      for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = 8'((c << 4) | w);
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr valid[%0d]", k), 32'(if_rr.out_valid), 32'h1);
      chk($sformatf("rr ch[%0d]", k),    32'(if_rr.out_ch),    32'(seq_tab[k].rr_ch));
      chk($sformatf("rr data[%0d]", k),  32'(if_rr.out_data),  32'(seq_tab[k].rr_data));
      chk($sformatf("fx valid[%0d]", k), 32'(if_fx.out_valid), 32'h1);
      chk($sformatf("fx ch[%0d]", k),    32'(if_fx.out_ch),    32'(seq_tab[k].fx_ch));
      chk($sformatf("fx data[%0d]", k),  32'(if_fx.out_data),  32'(seq_tab[k].fx_data));
      tick();
    end
    chk("rr drained", 32'(if_rr.out_valid), 32'h0);
    chk("fx drained", 32'(if_fx.out_valid), 32'h0);

    // Backpressure: 5 words into ch1 fill FIFO plus output register
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill in_ready1[%0d]", i), 32'(if_rr.in_ready[1]), 32'h1);
      in_valid = 4'b0010;
      in_data[1*DW +: DW] = 8'(8'h50 + i);
      tick();
    end
    chk("full in_ready", 32'(if_rr.in_ready), 32'hD);
    chk("full out_valid", 32'(if_rr.out_valid), 32'h1);
    chk("full out_data hold", 32'(if_rr.out_data), 32'h50);
    in_data[1*DW +: DW] = 8'h99;
    for (int i = 0; i < 3; i++) tick();
    chk("stalled out_data hold", 32'(if_rr.out_data), 32'h50);
    chk("stalled out_ch hold",   32'(if_rr.out_ch),   32'h1);
`ifdef CHAN_STATS_EN
    chk("stall_cnt[1]", 32'(if_rr.stall_cnt[1*16 +: 16]), 32'd3);
    chk("stall_cnt[0]", 32'(if_rr.stall_cnt[0 +: 16]),    32'd0);
`endif
    // Full FIFO popped while writer still asserts: word must be refused
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    chk("drain[0] data", 32'(if_rr.out_data), 32'(drain_exp[1]));
    chk("drain[0] fx data", 32'(if_fx.out_data), 32'(drain_exp[1]));
`ifdef CHAN_STATS_EN
    chk("stall_cnt[1] pop cycle", 32'(if_rr.stall_cnt[1*16 +: 16]), 32'd4);
`endif
    for (int k = 2; k < 5; k++) begin
      tick();
      chk($sformatf("drain[%0d] valid", k), 32'(if_rr.out_valid), 32'h1);
      chk($sformatf("drain[%0d] data", k),  32'(if_rr.out_data),  32'(drain_exp[k]));
    end
    tick();
    chk("drain no stale word", 32'(if_rr.out_valid), 32'h0);
    chk("drain ch_empty",      32'(if_rr.ch_empty),  32'hF);

    // Reset in the middle of traffic
    do_reset();
    in_valid = 4'hF;
    for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = 8'(8'hC0 + c);
    tick();
    in_valid = '0;
    tick();
    chk("pre-rst out_valid", 32'(if_rr.out_valid), 32'h1);
    chk("pre-rst ch_empty",  32'(if_rr.ch_empty),  32'h1);
    rst = 1'b1;
    tick();
    chk("mid-rst in_ready",  32'(if_rr.in_ready),  32'hF);
    chk("mid-rst ch_empty",  32'(if_rr.ch_empty),  32'hF);
    chk("mid-rst out_valid", 32'(if_rr.out_valid), 32'h0);
    chk("mid-rst out_data",  32'(if_rr.out_data),  32'h0);
    chk("mid-rst out_ch",    32'(if_rr.out_ch),    32'h0);
    chk("mid-rst fx ch_empty", 32'(if_fx.ch_empty), 32'hF);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-rst idle rr[%0d]", k), 32'(if_rr.out_valid), 32'h0);
      chk($sformatf("post-rst idle fx[%0d]", k), 32'(if_fx.out_valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_arb_array.md
Name: chan_arb_array

Overview:
- Parametrised multi-channel ingress block: NUM_CH independent valid/ready input channels, each buffered in its own FIFO.
- FIFOs are instantiated through a generate loop.
- The FIFOs drain into one registered output stream through an arbiter; the arbiter type is selected at elaboration by a generate case on ARB_MODE.
- Sits between per-source producers and a single shared downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DW, 8, data width per channel.
- DEPTH, 4, entries per channel FIFO (power of two, >=2).
- ARB_MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins). Any other value raises an elaboration $error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  NUM_CH  per-channel write request.
- in_data  in  NUM_CH*DW  channel c occupies bits [c*DW +: DW].
- in_ready  out  NUM_CH  per-channel FIFO not full.
- out_valid  out  1  output register holds valid data.
- out_data  out  DW  output data.
- out_ch  out  $clog2(NUM_CH)  source channel of out_data.
- out_ready  in  1  downstream accepts.
- ch_empty  out  NUM_CH  per-channel FIFO empty flag.
- stall_cnt  out  NUM_CH*16  present only with CHAN_STATS_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - All FIFOs empty: in_ready all 1, ch_empty all 1.
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer = NUM_CH-1, so ch0 has first priority.
  - stall_cnt = 0.
  - Reset asserted mid-operation discards all buffered and in-flight data in the same edge.
- FIFO push: push on in_valid[c] & in_ready[c]. in_ready[c] = !full[c], combinational from FIFO count.
- FIFO simultaneous push/pop: push and pop on the same FIFO in the same cycle are both legal; occupancy is unchanged.
- FIFO full: a full FIFO never accepts, even if it is being popped that cycle. There is no pass-through.
- Output stage:
  - Load enable: load_en = !out_valid | out_ready.
  - When load_en is high and any channel is non-empty, the arbiter grants one channel. That FIFO is popped, and out_data/out_ch/out_valid=1 are registered on the next edge.
  - When load_en is high and all channels are empty, out_valid goes to 0.
  - While out_valid & !out_ready, out_data and out_ch hold stable.
  - Full throughput: one word per cycle when out_ready is held high.
- Latency: word pushed at edge t is visible in the FIFO after t. It appears on out_valid/out_data at edge t+1 at the earliest (empty, idle pipeline, granted).
- Round-robin (ARB_MODE=0):
  - Search order is ptr+1, ptr+2, ... wrapping modulo NUM_CH.
  - The first non-empty channel is granted.
  - ptr updates to the granted channel only when a grant occurs.
- Fixed priority (ARB_MODE=1): the lowest-index non-empty channel is granted; there is no pointer.
- Width rules:
  - out_ch is zero-extended from the grant index.
  - FIFO read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - The count register is $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: CHAN_STATS_EN.
- Defined:
  - Port stall_cnt exists.
  - Per-channel 16-bit counter increments every cycle in_valid[c] & !in_ready[c], saturating at 16'hFFFF.
  - Cleared only by rst.
- Undefined: port and counters are absent. All other behaviour is identical.

Decomposition:
- Package chan_arb_pkg:
  - typedef enum arb_mode_e {ARB_RR=0, ARB_FIXED=1}.
  - localparam STALL_W=16.
  - Function next_rr_grant (request vector, pointer -> index).
- Sub-module chan_fifo (DW, DEPTH): synchronous FIFO with push, pop, full, empty, rdata. Instantiated NUM_CH times in a generate for loop.
- Arbiter implemented inline via a generate case on ARB_MODE.

Test Plan:
1. Reset then idle -> in_ready=4'hF, ch_empty=4'hF, out_valid=0, out_data=0.
2. Single push ch2 data 8'hA5, out_ready=1 -> next edge out_valid=1, out_data=8'hA5, out_ch=2; following cycle out_valid=0.
3. RR mode: all 4 channels hold 2 words each, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3, 8 consecutive valid cycles.
4. Fixed mode, same load -> out_ch sequence 0,0,1,1,2,2,3,3.
5. out_ready=0 with ch1 receiving 5 pushes, DEPTH=4 -> 4 in the FIFO plus 1 in the output register. After the 5th push, in_ready[1]=0. With CHAN_STATS_EN, 3 further in_valid cycles -> stall_cnt[1]=3.
6. rst asserted while out_valid=1 and FIFOs partly full -> next edge all flags at reset values, and no stale word emitted after release.
